serial_frame_receiver: RTL

//   Serial-in, parallel-out receiver; the receiving end of the team's PISO shift-out link.

---
 rtl/serial_frame_receiver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Serial-in, parallel-out frame receiver: start(0), WIDTH data bits LSB first, stop(1).
// Received words are delivered on a registered output with a valid/ready handshake.
module serial_frame_receiver #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             word_done;

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;
        word_done    = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        count_d = '0;
                    end
                end
                DATA: begin
                    shift_d[count_q] = sin;
                    count_d          = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (sin) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (sin) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A completing word is taken if the output slot is empty or being drained this edge
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Set has priority over clear
        if (clr_ovr && !(word_done && dout_valid_q && !dout_ready)) begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
